// File: rtl/zet_front_fifo.sv
// Instruction FIFO between the prefetcher and decode: stores fetched words tagged
// with their CS:IP, first-word-fall-through head, occupancy status and redirect flush.
module zet_front_fifo #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 3,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_fifo,
    input  logic [DATA_W-1:0]     fifo_dat_i,
    input  logic [ADDR_W-1:0]     cs_i,
    input  logic [ADDR_W-1:0]     ip_i,
    output logic                  fifo_full,
    output logic                  almost_full,
    input  logic                  rd_fifo,
    output logic                  valid,
    output logic [DATA_W-1:0]     fifo_dat_o,
    output logic [ADDR_W-1:0]     cs_o,
    output logic [ADDR_W-1:0]     ip_o,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = DATA_W + 2 * ADDR_W;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_THR   = (DEPTH_LOG2 + 1)'(DEPTH - AF_MARGIN);

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic [ENTRY_W-1:0]    head;
    logic                  we;
    logic                  re;

    // Status comes only from the registered count, so no request-to-status path exists.
    assign fifo_full   = (cnt == FULL_CNT);
    assign valid       = (cnt != '0);
    assign almost_full = (cnt >= AF_THR);
    assign count       = cnt;

    assign we = wr_fifo & ~fifo_full & ~flush;
    assign re = rd_fifo & valid & ~flush;

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[wr_ptr] <= {cs_i, ip_i, fifo_dat_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (re) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({we, re})
                2'b10:   cnt <= cnt + (DEPTH_LOG2 + 1)'(1);
                2'b01:   cnt <= cnt - (DEPTH_LOG2 + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head is forced to zero when empty so stale or unwritten storage never leaks out.
    assign head       = mem[rd_ptr];
    assign fifo_dat_o = valid ? head[DATA_W-1:0]                 : '0;
    assign ip_o       = valid ? head[DATA_W +: ADDR_W]           : '0;
    assign cs_o       = valid ? head[DATA_W + ADDR_W +: ADDR_W]  : '0;

endmodule

// File: tb/tb_zet_front_fifo.sv
// Directed bench for zet_front_fifo with DEPTH=4, AF_MARGIN=1: fill, full-with-read,
// streaming wrap-around, flush and reset scenarios against hand-computed values.
module tb_zet_front_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_fifo;
    logic [15:0] fifo_dat_i;
    logic [15:0] cs_i;
    logic [15:0] ip_i;
    logic        fifo_full;
    logic        almost_full;
    logic        rd_fifo;
    logic        valid;
    logic [15:0] fifo_dat_o;
    logic [15:0] cs_o;
    logic [15:0] ip_o;
    logic [2:0]  count;

    int assert_count = 0;
    int fail_count   = 0;
    logic [15:0] exp_q [$];

    zet_front_fifo #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(2), .AF_MARGIN(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_fifo(wr_fifo), .fifo_dat_i(fifo_dat_i), .cs_i(cs_i), .ip_i(ip_i),
        .fifo_full(fifo_full), .almost_full(almost_full),
        .rd_fifo(rd_fifo), .valid(valid),
        .fifo_dat_o(fifo_dat_o), .cs_o(cs_o), .ip_o(ip_o),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, clock it, and settle just after the edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic fl,
                                 input logic [15:0] d, input logic [15:0] c, input logic [15:0] i);
        wr_fifo    = wr;
        rd_fifo    = rd;
        flush      = fl;
        fifo_dat_i = d;
        cs_i       = c;
        ip_i       = i;
        @(posedge clk);
        #1;
        wr_fifo = 1'b0;
        rd_fifo = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
        checkOutput({tag, "_full"},  32'(fifo_full), 32'd0);
        checkOutput({tag, "_af"},    32'(almost_full), 32'd0);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_dat"},   32'(fifo_dat_o), 32'd0);
        checkOutput({tag, "_cs"},    32'(cs_o), 32'd0);
        checkOutput({tag, "_ip"},    32'(ip_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; wr_fifo = 1'b0; rd_fifo = 1'b0;
        fifo_dat_i = '0; cs_i = '0; ip_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0);
        $display("[TB] reset and idle");
        checkIdle("reset");

        // Consecutive writes, no reads
        applyStimulus(1, 0, 0, 16'h1111, 16'hF000, 16'h0000);
        checkOutput("w1_valid", 32'(valid), 32'd1);
        checkOutput("w1_dat",   32'(fifo_dat_o), 32'h1111);
        checkOutput("w1_cs",    32'(cs_o), 32'hF000);
        checkOutput("w1_ip",    32'(ip_o), 32'h0000);
        checkOutput("w1_af",    32'(almost_full), 32'd0);
        applyStimulus(1, 0, 0, 16'h2222, 16'hF000, 16'h0002);
        applyStimulus(1, 0, 0, 16'h3333, 16'hF000, 16'h0004);
        checkOutput("w3_count", 32'(count), 32'd3);
        checkOutput("w3_af",    32'(almost_full), 32'd1);
        checkOutput("w3_full",  32'(fifo_full), 32'd0);
        checkOutput("w3_dat",   32'(fifo_dat_o), 32'h1111);

        // Full, then write+read together: write dropped, only the read happens
        applyStimulus(1, 0, 0, 16'h4444, 16'hF000, 16'h0006);
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_flag",  32'(fifo_full), 32'd1);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("full_hold_count", 32'(count), 32'd4);
        applyStimulus(1, 1, 0, 16'h5555, 16'hF000, 16'h0008);
        checkOutput("fullrw_count", 32'(count), 32'd3);
        checkOutput("fullrw_full",  32'(fifo_full), 32'd0);
        checkOutput("fullrw_dat",   32'(fifo_dat_o), 32'h2222);
        checkOutput("fullrw_ip",    32'(ip_o), 32'h0002);
        applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("drain1_dat", 32'(fifo_dat_o), 32'h3333);
        applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("drain2_dat", 32'(fifo_dat_o), 32'h4444);
        checkOutput("drain2_ip",  32'(ip_o), 32'h0006);
        applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h0);
        checkIdle("drained");
        applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("underflow_count", 32'(count), 32'd0);

        // Streaming at count=2 across several pointer wraps
        applyStimulus(1, 0, 0, 16'h0101, 16'h0000, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0202, 16'h0000, 16'h0000);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0202);
        checkOutput("stream_pre_count", 32'(count), 32'd2);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("stream%0d_dat", k), 32'(fifo_dat_o), 32'(exp_q[0]));
            exp_q.push_back(16'hA000 + 16'(k));
            void'(exp_q.pop_front());
            applyStimulus(1, 1, 0, 16'hA000 + 16'(k), 16'h0000, 16'(k));
            checkOutput($sformatf("stream%0d_count", k), 32'(count), 32'd2);
        end
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("stream_tail%0d_dat", k), 32'(fifo_dat_o), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h0);
        end
        checkOutput("stream_end_count", 32'(count), 32'd0);

        // Flush with a concurrent write and read at count=3
        applyStimulus(1, 0, 0, 16'h0001, 16'h0000, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0002, 16'h0000, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0003, 16'h0000, 16'h0000);
        checkOutput("preflush_count", 32'(count), 32'd3);
        applyStimulus(1, 1, 1, 16'hBEEF, 16'hFFFF, 16'hFFFF);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(valid), 32'd0);
        checkOutput("flush_dat",   32'(fifo_dat_o), 32'd0);
        applyStimulus(1, 0, 0, 16'hCAFE, 16'h1234, 16'h0010);
        checkOutput("postflush_dat",   32'(fifo_dat_o), 32'hCAFE);
        checkOutput("postflush_cs",    32'(cs_o), 32'h1234);
        checkOutput("postflush_ip",    32'(ip_o), 32'h0010);
        checkOutput("postflush_count", 32'(count), 32'd1);

        // Empty with simultaneous write and read, then reset at count=2
        applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("empty_again_count", 32'(count), 32'd0);
        applyStimulus(1, 1, 0, 16'h7777, 16'h0040, 16'h0020);
        checkOutput("emptyrw_count", 32'(count), 32'd1);
        checkOutput("emptyrw_valid", 32'(valid), 32'd1);
        checkOutput("emptyrw_dat",   32'(fifo_dat_o), 32'h7777);
        checkOutput("emptyrw_cs",    32'(cs_o), 32'h0040);
        applyStimulus(1, 0, 0, 16'h8888, 16'h0040, 16'h0022);
        checkOutput("prereset_count", 32'(count), 32'd2);
        rst = 1'b1;
        applyStimulus(1, 1, 1, 16'h9999, 16'h0, 16'h0);
        rst = 1'b0;
        checkIdle("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/zet_front_fifo.md
Name: zet_front_fifo

Overview:
- Parametrised instruction FIFO between the front-end prefetcher and the decode stage.
- Each entry holds one fetched word tagged with the CS:IP it was fetched from.
- Provides first-word-fall-through read, full, almost-full and occupancy status, and a synchronous flush for branch/IP redirect.
- Replaces the constant-zero fifo_full tie-off in the core with real back-pressure.

Parameters:
- DATA_W, 16, width of the fetched instruction word.
- ADDR_W, 16, width of each of the CS and IP tags.
- DEPTH_LOG2, 3, log2 of entry count; DEPTH = 2**DEPTH_LOG2, legal range 1..6.
- AF_MARGIN, 2, almost_full asserts when count >= DEPTH - AF_MARGIN; legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all entries; synchronous.
- wr_fifo  in  1  write request from prefetch.
- fifo_dat_i  in  DATA_W  word to store.
- cs_i  in  ADDR_W  CS tag of the word.
- ip_i  in  ADDR_W  IP tag of the word.
- fifo_full  out  1  no free entry; writes are ignored.
- almost_full  out  1  occupancy threshold reached.
- rd_fifo  in  1  pop request from decode.
- valid  out  1  head entry present (not empty).
- fifo_dat_o  out  DATA_W  head word.
- cs_o  out  ADDR_W  head CS tag.
- ip_o  out  ADDR_W  head IP tag.
- count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at a clock edge): write pointer, read pointer and count go to 0. Outputs then read valid=0, fifo_full=0, almost_full=(AF_MARGIN>=DEPTH ? 1 : 0), which is 0 for all legal values, and count=0. Storage contents are not reset. rst dominates flush, wr_fifo and rd_fifo.
- Storage: DEPTH entries of {cs, ip, data}, DATA_W+2*ADDR_W bits each. Pointers are DEPTH_LOG2 bits wide and wrap naturally modulo DEPTH.
- Status derivation: all status outputs are combinational from the registered count only, with no combinational path from wr_fifo or rd_fifo.
  - fifo_full = (count == DEPTH)
  - valid = (count != 0)
  - almost_full = (count >= DEPTH - AF_MARGIN)
- Write accept: we = wr_fifo & ~fifo_full & ~flush. On we, the entry is stored at the write pointer and the write pointer increments.
- Read accept: re = rd_fifo & valid & ~flush. On re, the read pointer increments.
- Count update: count_next = count + we - re. A simultaneous accepted write and read leaves count unchanged.
- Full with simultaneous rd_fifo: the write is still rejected, because fifo_full is based on the pre-edge count. Only the read happens and count decrements by 1. The prefetcher must hold its word and retry.
- Empty with simultaneous wr_fifo and rd_fifo: the read is ignored (valid=0). The write lands, and valid=1 with the new head appears on the following cycle.
- Write-to-read latency: a word written at edge N is visible on fifo_dat_o/cs_o/ip_o with valid=1 immediately after edge N when the FIFO was empty. There is no extra output register.
- Head outputs (first-word-fall-through): fifo_dat_o, cs_o and ip_o show the entry at the read pointer combinationally from storage. When valid=0 they are forced to all zeros, so they are never X after reset.
- rd_fifo and wr_fifo while the FIFO cannot accept them are legal; they are simply ignored, with no error state.
- Flush (flush=1, rst=0 at an edge): both pointers and count go to 0. Any write or read presented in the same cycle is discarded. A write presented in the cycle after flush is accepted normally.
- Wrap-around: the pointers cross DEPTH-1 to 0 without a bubble. Continuous simultaneous read and write at full rate sustains 1 word/cycle indefinitely, at any occupancy from 1 to DEPTH-1.

Test Plan:
Benches use DEPTH_LOG2=2 (DEPTH=4) and AF_MARGIN=1 unless stated otherwise.
1. Reset then idle → valid=0, fifo_full=0, almost_full=0, count=0, fifo_dat_o/cs_o/ip_o=0.
2. Write 0x1111@F000:0000, 0x2222@F000:0002, 0x3333@F000:0004 on consecutive cycles with no reads.
   - After the first edge: valid=1, fifo_dat_o=0x1111, cs_o=0xF000, ip_o=0x0000.
   - After the third edge: count=3, almost_full=1, fifo_full=0.
3. Fill to 4 entries, then hold wr_fifo=1 with 0x5555 and rd_fifo=1 for one cycle.
   - The write is dropped and count=3.
   - The head advances to the second entry.
   - 0x5555 is never read out.
4. From count=2, run 10 cycles of simultaneous write and read with incrementing data 0xA000..0xA009.
   - count stays 2 throughout.
   - Read-out order is the 2 original words, then 0xA000..0xA007.
   - The pointers wrap at least twice with no loss or duplication.
5. With count=3, assert flush together with wr_fifo=1 (0xBEEF) and rd_fifo=1.
   - Next cycle: count=0 and valid=0.
   - The following write of 0xCAFE@1234:0010 produces head 0xCAFE, cs_o=0x1234, ip_o=0x0010.
6. Empty FIFO with wr_fifo=1 and rd_fifo=1 in the same cycle → count=1 and valid=1 next cycle; no underflow. Then assert rst while count=2 → the next cycle matches scenario 1.
